// File: rtl/ring_count_monitor.sv
// Checker for a one-hot ring counter bus: verifies rotation, tracks lock,
// counts faults and revolutions, and reports the encoded phase.
module ring_count_monitor #(
    parameter int WIDTH     = 4,
    parameter bit DIR       = 1'b0,
    parameter int LOCK_REVS = 2,
    parameter int REV_W     = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic                     Clear,
    input  logic [WIDTH-1:0]         Count_in,
    output logic [$clog2(WIDTH)-1:0] Phase,
    output logic                     Locked,
    output logic                     Error,
    output logic [7:0]               Err_count,
    output logic [REV_W-1:0]         Rev_count
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_REVS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] samp, samp_d;
    logic             en_s, en_d;
    logic [CW-1:0]    clean, clean_n;
    logic             error_n;
    logic [7:0]       errc_n;
    logic [REV_W-1:0] rev_n;

    logic [WIDTH-1:0] rot;
    logic [PW-1:0]    enc;
    logic             valid;
    logic             match;
    logic             wrap;
    logic             check;

    // Input pipeline; en_d trails en_s so the first enabled cycle only re-arms.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            samp   <= '0;
            samp_d <= '0;
            en_s   <= 1'b0;
            en_d   <= 1'b0;
        end else begin
            samp   <= Count_in;
            samp_d <= samp;
            en_s   <= Enable;
            en_d   <= en_s;
        end
    end

    generate
        if (DIR == 1'b0) begin : g_left
            assign rot  = {samp_d[WIDTH-2:0], samp_d[WIDTH-1]};
            assign wrap = match & samp[0];
        end else begin : g_right
            assign rot  = {samp_d[0], samp_d[WIDTH-1:1]};
            assign wrap = match & samp[WIDTH-1];
        end
    endgenerate

    assign valid = (samp != '0) && ((samp & (samp - 1'b1)) == '0);
    assign match = valid && (samp == rot);
    assign check = en_s & en_d;

    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (samp[i]) begin
                enc = PW'(i);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Phase <= '0;
        end else if (valid) begin
            Phase <= enc;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            clean     <= '0;
            Error     <= 1'b0;
            Err_count <= '0;
            Rev_count <= '0;
        end else begin
            state     <= state_n;
            clean     <= clean_n;
            Error     <= error_n;
            Err_count <= errc_n;
            Rev_count <= rev_n;
        end
    end

    always_comb begin
        state_n = state;
        clean_n = clean;
        error_n = Error;
        errc_n  = Err_count;
        rev_n   = Rev_count;
        if (Clear) begin
            state_n = IDLE;
            clean_n = '0;
            error_n = 1'b0;
            errc_n  = '0;
            rev_n   = '0;
        end else if (check) begin
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        state_n = TRACK;
                        clean_n = '0;
                    end
                end
                TRACK: begin
                    if (!match) begin
                        state_n = FAULT;
                    end else if (wrap) begin
                        clean_n = clean + CW'(1);
                        if (clean == CW'(LOCK_REVS - 1)) begin
                            state_n = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state_n = FAULT;
                    end else if (wrap) begin
                        rev_n = Rev_count + 1'b1;
                    end
                end
                FAULT: begin
                    if (valid) begin
                        state_n = TRACK;
                        clean_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
            // Count entries into FAULT only, never residency.
            if (state_n == FAULT && state != FAULT) begin
                error_n = 1'b1;
                errc_n  = (Err_count == 8'hFF) ? 8'hFF : Err_count + 8'd1;
            end
        end
    end

    assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_ring_count_monitor.sv
// Directed bench for ring_count_monitor, WIDTH=4, DIR=0, LOCK_REVS=2.
module tb_ring_count_monitor;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic        Clear;
    logic [3:0]  Count_in;
    logic [1:0]  Phase;
    logic        Locked;
    logic        Error;
    logic [7:0]  Err_count;
    logic [15:0] Rev_count;

    int total = 0;
    int bad   = 0;
    logic [3:0] cur;

    ring_count_monitor #(
        .WIDTH(4),
        .DIR(1'b0),
        .LOCK_REVS(2),
        .REV_W(16)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable(Enable),
        .Clear(Clear),
        .Count_in(Count_in),
        .Phase(Phase),
        .Locked(Locked),
        .Error(Error),
        .Err_count(Err_count),
        .Rev_count(Rev_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] p);
        Count_in = p;
        @(posedge Clock);
        #1;
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) begin
            cur = {cur[2:0], cur[3]};
            drive(cur);
        end
    endtask

    initial begin
        Reset    = 1'b0;
        Enable   = 1'b0;
        Clear    = 1'b0;
        Count_in = 4'b0000;
        cur      = 4'b1000;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_locked", Locked, 0);
        chk("rst_error", Error, 0);
        chk("rst_errc", Err_count, 0);
        chk("rst_rev", Rev_count, 0);
        chk("rst_phase", Phase, 0);
        Reset  = 1'b1;
        Enable = 1'b1;

        // 1: lock-up from clean rotation
        go(2);
        chk("t1_phase0", Phase, 0);
        go(1);
        chk("t1_phase1", Phase, 1);
        go(1);
        chk("t1_phase2", Phase, 2);
        go(1);
        chk("t1_phase3", Phase, 3);
        go(4);
        chk("t1_not_yet", Locked, 0);
        go(1);
        chk("t1_locked", Locked, 1);
        chk("t1_error", Error, 0);
        chk("t1_rev_lockwrap", Rev_count, 0);
        go(4);
        chk("t1_rev1", Rev_count, 1);
        chk("t1_still", Locked, 1);

        // 2: multi-hot glitch then relock
        drive(4'b0011);
        chk("t2_pre", Locked, 1);
        go(1);
        chk("t2_error", Error, 1);
        chk("t2_unlock", Locked, 0);
        chk("t2_errc", Err_count, 1);
        chk("t2_phase_hold", Phase, 1);
        go(6);
        chk("t2_relock_early", Locked, 0);
        go(1);
        chk("t2_relock", Locked, 1);
        chk("t2_sticky", Error, 1);
        chk("t2_errc_keep", Err_count, 1);
        chk("t2_rev_keep", Rev_count, 1);

        // 3: skipped phase
        go(3);
        cur = 4'b0100;
        drive(cur);
        cur = 4'b1000;
        drive(cur);
        chk("t3_errc", Err_count, 2);
        chk("t3_unlock", Locked, 0);
        chk("t3_rev", Rev_count, 2);
        go(1);
        chk("t3_no_recount", Err_count, 2);
        go(5);
        chk("t3_relock", Locked, 1);
        chk("t3_rev_keep", Rev_count, 2);

        // 4: saturation of fault count
        for (int i = 0; i < 300; i++) begin
            drive(4'b0011);
            drive(4'b0001);
            if (i == 99) chk("t4_errc_mid", Err_count, 102);
        end
        chk("t4_sat", Err_count, 255);
        chk("t4_error", Error, 1);
        chk("t4_unlock", Locked, 0);
        cur = 4'b0001;

        // 5: Clear coincident with a bad check
        go(2);
        drive(4'b0011);
        Clear = 1'b1;
        cur   = 4'b1000;
        drive(cur);
        Clear = 1'b0;
        chk("t5_error", Error, 0);
        chk("t5_errc", Err_count, 0);
        chk("t5_rev", Rev_count, 0);
        chk("t5_locked", Locked, 0);
        chk("t5_phase", Phase, 2);
        go(1);
        chk("t5_no_fault", Error, 0);
        chk("t5_errc_zero", Err_count, 0);
        chk("t5_phase3", Phase, 3);

        // 6: pause with frozen ring, then async reset
        go(8);
        chk("t6_locked", Locked, 1);
        chk("t6_rev0", Rev_count, 0);
        go(2);
        chk("t6_rev1", Rev_count, 1);
        Enable = 1'b0;
        repeat (10) drive(4'b0100);
        chk("t6_frz_locked", Locked, 1);
        chk("t6_frz_error", Error, 0);
        chk("t6_frz_rev", Rev_count, 1);
        chk("t6_frz_phase", Phase, 2);
        Enable = 1'b1;
        go(4);
        chk("t6_res_locked", Locked, 1);
        chk("t6_res_error", Error, 0);
        chk("t6_res_errc", Err_count, 0);
        chk("t6_res_rev", Rev_count, 2);
        go(1);
        chk("t6_phase", Phase, 2);
        #1;
        Reset = 1'b0;
        #1;
        chk("t6_ar_locked", Locked, 0);
        chk("t6_ar_rev", Rev_count, 0);
        chk("t6_ar_phase", Phase, 0);
        chk("t6_ar_error", Error, 0);
        chk("t6_ar_errc", Err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
